rgb_pwm_gen: RTL and testbench
==============================

Name: rgb_pwm_gen

Overview:
Downstream consumer of the PWM register-file hardware outputs; turns the per-channel LUT settings into three PWM pins (red, green, blue).
- Each channel runs a phase accumulator stepped once every sweep_time PWM frames.
- The phase is mapped through an arithmetic triangle wave and scaled by magnitude to give the duty cycle.
- Output sits at the LED driver pins of the SoC.

Parameters:
SLOT_W, 16, width of time_slots / slot counter
SWEEP_W, 16, width of sweep_time / frame counter
ACC_W, 16, phase accumulator width; phase index = acc[ACC_W-1 -: 9]

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pwm_en  in  1  level enable; 0 forces IDLE
time_slots  in  16  PWM frame length in clk cycles
sweep_time  in  16  frames per phase step; 0 = phase frozen
red_freq / green_freq / blue_freq  in  13 each  phase increment per step, added to acc
red_mag / green_mag / blue_mag  in  2 each  amplitude right-shift (0 = full, 3 = 1/8)
red_phase / green_phase / blue_phase  in  9 each  initial phase index
pwm_r / pwm_g / pwm_b  out  1 each  registered PWM outputs
frame_start  out  1  one-cycle pulse on the first slot of each frame
active  out  1  high while in RUN

Behaviour:
- Reset: pwm_r/g/b=0, frame_start=0, active=0, state IDLE, all counters/accumulators/shadows=0.
- FSM IDLE -> RUN when pwm_en=1 && time_slots!=0. On that edge:
  - latch shadows: time_slots, sweep_time, freq, mag;
  - acc_c = {phase_c, 7'b0};
  - slot_cnt=0, sweep_cnt=0.
- RUN -> IDLE when pwm_en=0, or when time_slots==0 is sampled at a frame boundary. On that edge:
  - outputs forced 0 (registered, so low on the next cycle);
  - accumulators hold, but are reloaded on the next IDLE->RUN.
- slot_cnt counts 0..ts_sh-1 and wraps. Frame boundary = the cycle slot_cnt==ts_sh-1. At a boundary:
  - re-latch time_slots/freq/mag/sweep_time shadows; input changes mid-frame are invisible until then;
  - phase inputs are never re-sampled in RUN.
- Sweep: at each frame boundary, if sw_sh!=0 then sweep_cnt++. When sweep_cnt reaches sw_sh-1:
  - sweep_cnt=0;
  - acc_c += zero-extended freq_c, mod 2^ACC_W, wrapping silently.
  - If sw_sh==0: sweep_cnt and acc hold.
- Duty per channel (combinational from acc and shadows, registered into the compare):
  - p = acc[15:7] (9 bits);
  - tri = p[8] ? ~p[7:0] : p[7:0] (0..255);
  - lvl = tri >> mag;
  - duty = (lvl * ts_sh) >> 8 (8x16 multiply, keep bits [23:8]).
- Duty is latched into duty_q_c only at the frame boundary (and on IDLE->RUN). This keeps it glitch-free within a frame.
- Output: pwm_c registered = (state==RUN) && (slot_cnt < duty_q_c).
  - Latency: first high cycle one clk after RUN entry.
  - duty 0 -> constantly low; duty is never >= ts_sh, so there is at most ts_sh-1 high cycles per frame.
- frame_start is a registered pulse in the cycle pwm outputs reflect slot 0, including the first frame after RUN entry.
- active = (state==RUN).
- rst asserted mid-frame: immediate asynchronous return to reset values; no partial frame completion.
- Simultaneous pwm_en fall and frame boundary: the disable wins; no accumulator step is taken.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum {IDLE, RUN};
  - typedef chan_cfg_t {freq[12:0], mag[1:0], phase[8:0]};
  - localparams TRI_W=8, PHASE_IDX_W=9.
- Sub-module pwm_chan, instantiated 3 times. Per channel it contains:
  - accumulator;
  - freq/mag shadow;
  - triangle/scale/multiply;
  - duty_q and output compare.
- pwm_chan takes common slot_cnt, frame_boundary, step, load and run strobes from the top.
- The top owns the FSM, slot/sweep counters, the time_slots/sweep_time shadows, frame_start and active.

Test Plan:
1. time_slots=256, red_phase=0x040, red_mag=0, sweep_time=0, pwm_en=1 -> pwm_r high 64 of every 256 cycles; frame_start every 256 cycles; phase never changes.
2. time_slots=100, green_phase=0x100, green_mag=2 -> tri=255, lvl=63, duty=(63*100)>>8=24; pwm_g high 24 of 100 cycles.
3. time_slots=16, sweep_time=2, blue_freq=0x080, blue_phase=0 -> duty recomputed every 2 frames with p stepping 0,1,2,...
   - p=255 -> p=256 gives tri 255->255; p=257 -> 254.
   - acc wraps 0xFF80 -> 0x0000 without a glitch.
4. Mid-frame write of time_slots 256 -> 128 at slot 50 -> the current frame still lasts 256 cycles; the next frame lasts 128 cycles; duty rescaled at the boundary.
5. pwm_en deasserted at the same cycle as a frame boundary with a step due -> outputs 0 next cycle; active=0; re-enable reloads acc from phase inputs.
6. rst pulsed mid-frame while in RUN -> all outputs 0 immediately (asynchronously); with pwm_en still 1, after rst release RUN re-entered next edge and first frame_start one cycle later.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the RGB PWM generator.
//   pwm_state_t : controller state (IDLE / RUN)
//   chan_cfg_t  : per-channel LUT settings (freq, mag, phase)
//   tri_level() : phase index -> triangle wave -> amplitude-scaled level
package pwm_pkg;

  typedef enum logic {IDLE, RUN} pwm_state_t;

  localparam int unsigned TRI_W       = 8;
  localparam int unsigned PHASE_IDX_W = 9;
  localparam int unsigned FREQ_W      = 13;
  localparam int unsigned MAG_W       = 2;

  typedef struct packed {
    logic [FREQ_W-1:0]      freq;
    logic [MAG_W-1:0]       mag;
    logic [PHASE_IDX_W-1:0] phase;
  } chan_cfg_t;

  // Upper half of the phase circle mirrors the lower half, giving 0..255..0.
  function automatic logic [TRI_W-1:0] tri_level(input logic [PHASE_IDX_W-1:0] p,
                                                 input logic [MAG_W-1:0]       mag);
    logic [TRI_W-1:0] tw;
    tw = p[PHASE_IDX_W-1] ? ~p[TRI_W-1:0] : p[TRI_W-1:0];
    return tw >> mag;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: phase accumulator, freq shadow, duty computation and
// output compare.
//   clk, rst        : clock, asynchronous active-high reset
//   cfg             : live channel settings (freq, mag, phase)
//   time_slots      : live frame length, used to scale duty when latched
//   slot_cnt        : common slot counter from the controller
//   load            : IDLE->RUN strobe, reloads acc from phase
//   frame_boundary  : frame end while staying in RUN, re-latches duty/freq
//   step            : advance acc by the shadowed freq
//   run             : controller stays in RUN this cycle
//   pwm             : registered PWM output
module pwm_chan import pwm_pkg::*; #(
  parameter int SLOT_W = 16,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  chan_cfg_t         cfg,
  input  logic [SLOT_W-1:0] time_slots,
  input  logic [SLOT_W-1:0] slot_cnt,
  input  logic              load,
  input  logic              frame_boundary,
  input  logic              step,
  input  logic              run,
  output logic              pwm
);

  localparam int PROD_W = TRI_W + SLOT_W;

  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [FREQ_W-1:0] freq_sh;
  logic [SLOT_W-1:0] duty_q, duty_nxt;
  logic [TRI_W-1:0]  lvl;
  logic [PROD_W-1:0] prod;

  // Duty is derived from the post-step accumulator and the settings that
  // take effect for the coming frame, so a step shows up in the very next frame.
  always_comb begin
    acc_nxt = acc;
    if (load)
      acc_nxt = {cfg.phase, {(ACC_W-PHASE_IDX_W){1'b0}}};
    else if (step)
      acc_nxt = acc + ACC_W'(freq_sh);
    lvl      = tri_level(acc_nxt[ACC_W-1 -: PHASE_IDX_W], cfg.mag);
    prod     = PROD_W'(lvl) * PROD_W'(time_slots);
    duty_nxt = SLOT_W'(prod >> TRI_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      freq_sh <= '0;
      duty_q  <= '0;
      pwm     <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (load || frame_boundary) begin
        freq_sh <= cfg.freq;
        duty_q  <= duty_nxt;
      end
      pwm <= run && (slot_cnt < duty_q);
    end
  end

endmodule

// File: rtl/rgb_pwm_gen.sv
// RGB PWM generator: three triangle-wave swept PWM channels driven from a
// common frame/sweep controller.
//   clk, rst                 : clock, asynchronous active-high reset
//   pwm_en                   : level enable
//   time_slots               : frame length in clk cycles (0 stops at frame end)
//   sweep_time               : frames per phase step (0 freezes phase)
//   {red,green,blue}_freq    : phase increment per step
//   {red,green,blue}_mag     : amplitude right-shift
//   {red,green,blue}_phase   : initial phase index, loaded on RUN entry
//   pwm_r, pwm_g, pwm_b      : registered PWM outputs
//   frame_start              : pulse while outputs reflect slot 0
//   active                   : high while running
module rgb_pwm_gen import pwm_pkg::*; #(
  parameter int SLOT_W  = 16,
  parameter int SWEEP_W = 16,
  parameter int ACC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwm_en,
  input  logic [SLOT_W-1:0]  time_slots,
  input  logic [SWEEP_W-1:0] sweep_time,
  input  logic [12:0]        red_freq,
  input  logic [12:0]        green_freq,
  input  logic [12:0]        blue_freq,
  input  logic [1:0]         red_mag,
  input  logic [1:0]         green_mag,
  input  logic [1:0]         blue_mag,
  input  logic [8:0]         red_phase,
  input  logic [8:0]         green_phase,
  input  logic [8:0]         blue_phase,
  output logic               pwm_r,
  output logic               pwm_g,
  output logic               pwm_b,
  output logic               frame_start,
  output logic               active
);

  pwm_state_t         state;
  logic [SLOT_W-1:0]  slot_cnt, ts_sh;
  logic [SWEEP_W-1:0] sweep_cnt, sw_sh;
  logic               bnd, load, run_nxt, upd, step;
  chan_cfg_t          cfg_r, cfg_g, cfg_b;

  assign cfg_r = '{freq: red_freq,   mag: red_mag,   phase: red_phase};
  assign cfg_g = '{freq: green_freq, mag: green_mag, phase: green_phase};
  assign cfg_b = '{freq: blue_freq,  mag: blue_mag,  phase: blue_phase};

  // run_nxt folds both exit conditions so a disable coinciding with a frame
  // boundary suppresses the boundary update and any step.
  always_comb begin
    bnd     = (state == RUN) && (slot_cnt == ts_sh - SLOT_W'(1));
    load    = (state == IDLE) && pwm_en && (time_slots != '0);
    run_nxt = (state == RUN) && pwm_en && !(bnd && (time_slots == '0));
    upd     = bnd && run_nxt;
    step    = upd && (sw_sh != '0) && (sweep_cnt >= sw_sh - SWEEP_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      sweep_cnt   <= '0;
      ts_sh       <= '0;
      sw_sh       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= run_nxt && (slot_cnt == '0);
      case (state)
        IDLE: begin
          if (load) begin
            state     <= RUN;
            ts_sh     <= time_slots;
            sw_sh     <= sweep_time;
            slot_cnt  <= '0;
            sweep_cnt <= '0;
          end
        end
        RUN: begin
          if (!run_nxt) begin
            state <= IDLE;
          end else if (bnd) begin
            slot_cnt <= '0;
            ts_sh    <= time_slots;
            sw_sh    <= sweep_time;
            if (sw_sh != '0)
              sweep_cnt <= step ? '0 : sweep_cnt + SWEEP_W'(1);
          end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active = (state == RUN);

  pwm_chan #(.SLOT_W(SLOT_W), .ACC_W(ACC_W)) u_chan_r (
    .clk(clk), .rst(rst), .cfg(cfg_r), .time_slots(time_slots), .slot_cnt(slot_cnt),
    .load(load), .frame_boundary(upd), .step(step), .run(run_nxt), .pwm(pwm_r)
  );

  pwm_chan #(.SLOT_W(SLOT_W), .ACC_W(ACC_W)) u_chan_g (
    .clk(clk), .rst(rst), .cfg(cfg_g), .time_slots(time_slots), .slot_cnt(slot_cnt),
    .load(load), .frame_boundary(upd), .step(step), .run(run_nxt), .pwm(pwm_g)
  );

  pwm_chan #(.SLOT_W(SLOT_W), .ACC_W(ACC_W)) u_chan_b (
    .clk(clk), .rst(rst), .cfg(cfg_b), .time_slots(time_slots), .slot_cnt(slot_cnt),
    .load(load), .frame_boundary(upd), .step(step), .run(run_nxt), .pwm(pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed self-checking bench for rgb_pwm_gen.
module tb_rgb_pwm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_en = 1'b0;
  logic [15:0] time_slots = '0;
  logic [15:0] sweep_time = '0;
  logic [12:0] red_freq = '0, green_freq = '0, blue_freq = '0;
  logic [1:0]  red_mag = '0, green_mag = '0, blue_mag = '0;
  logic [8:0]  red_phase = '0, green_phase = '0, blue_phase = '0;
  logic        pwm_r, pwm_g, pwm_b, frame_start, active;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb_pwm_gen #(.SLOT_W(16), .SWEEP_W(16), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .pwm_en(pwm_en), .time_slots(time_slots), .sweep_time(sweep_time),
    .red_freq(red_freq), .green_freq(green_freq), .blue_freq(blue_freq),
    .red_mag(red_mag), .green_mag(green_mag), .blue_mag(blue_mag),
    .red_phase(red_phase), .green_phase(green_phase), .blue_phase(blue_phase),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .frame_start(frame_start), .active(active)
  );

  // Reference duty: triangle via reflection about 256, then scale.
  function automatic int exp_duty(input int p, input int mag, input int ts);
    int t;
    t = (p >= 256) ? (511 - p) : p;
    t = t >> mag;
    return (t * ts) / 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample n cycles, counting high outputs and frame_start pulses.
  task automatic run_count(input int n, output int hr, output int hg, output int hb,
                           output int fs, output logic fs0);
    hr = 0; hg = 0; hb = 0; fs = 0; fs0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b); fs += int'(frame_start);
      if (i == 0) fs0 = frame_start;
    end
  endtask

  task automatic go_idle();
    pwm_en = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin n_err++; $display("FAIL reset_pwm got=%b exp=000", {pwm_r, pwm_g, pwm_b}); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active got=%b exp=0", active); end
    rst = 1'b0;
    tick();
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL idle_after_reset got=%b exp=0", active); end
  endtask

  task automatic test_static_red();
    int hr, hg, hb, fs; logic fs0;
    time_slots = 16'd256; sweep_time = 16'd0;
    red_phase = 9'h040; green_phase = '0; blue_phase = '0;
    red_mag = 2'd0; green_mag = 2'd0; blue_mag = 2'd0;
    pwm_en = 1'b1;
    tick();
    n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL t1_active got=%b exp=1", active); end
    n_vec++; if (pwm_r !== 1'b0 || frame_start !== 1'b0) begin n_err++; $display("FAIL t1_entry got=%b%b exp=00", pwm_r, frame_start); end
    run_count(512, hr, hg, hb, fs, fs0);
    n_vec++; if (hr !== 128) begin n_err++; $display("FAIL t1_red_high got=%0d exp=128", hr); end
    n_vec++; if (hg !== 0 || hb !== 0) begin n_err++; $display("FAIL t1_gb_high got=%0d/%0d exp=0/0", hg, hb); end
    n_vec++; if (fs !== 2 || fs0 !== 1'b1) begin n_err++; $display("FAIL t1_frame_start got=%0d/%b exp=2/1", fs, fs0); end
    go_idle();
  endtask

  task automatic test_triangle_mag();
    int hr, hg, hb, fs; logic fs0;
    time_slots = 16'd100; sweep_time = 16'd0;
    red_phase = 9'h180; red_mag = 2'd3;
    green_phase = 9'h100; green_mag = 2'd2;
    blue_phase = 9'h0FF; blue_mag = 2'd0;
    pwm_en = 1'b1;
    tick();
    run_count(200, hr, hg, hb, fs, fs0);
    n_vec++; if (hg !== 48) begin n_err++; $display("FAIL t2_green got=%0d exp=48", hg); end
    n_vec++; if (hr !== 10) begin n_err++; $display("FAIL t2_red got=%0d exp=10", hr); end
    n_vec++; if (hb !== 198) begin n_err++; $display("FAIL t2_blue_max got=%0d exp=198", hb); end
    n_vec++; if (fs !== 2) begin n_err++; $display("FAIL t2_frame_start got=%0d exp=2", fs); end
    go_idle();
  endtask

  task automatic test_sweep();
    int hr, hg, hb, fs; logic fs0;
    int pb, pr;
    time_slots = 16'd16; sweep_time = 16'd2;
    blue_freq = 13'h080; blue_phase = 9'h000; blue_mag = 2'd0;
    red_freq = 13'h0C00; red_phase = 9'h1F0; red_mag = 2'd1;
    green_freq = '0; green_phase = '0; green_mag = '0;
    pwm_en = 1'b1;
    tick();
    for (int f = 0; f < 1030; f++) begin
      run_count(16, hr, hg, hb, fs, fs0);
      pb = (f / 2) % 512;
      pr = ((32'h1F0 * 128 + 32'hC00 * (f / 2)) % 65536) / 128;
      n_vec++; if (hb !== exp_duty(pb, 0, 16)) begin n_err++; $display("FAIL t3_blue f=%0d got=%0d exp=%0d", f, hb, exp_duty(pb, 0, 16)); end
      n_vec++; if (hr !== exp_duty(pr, 1, 16)) begin n_err++; $display("FAIL t3_red f=%0d got=%0d exp=%0d", f, hr, exp_duty(pr, 1, 16)); end
      n_vec++; if (fs0 !== 1'b1 || fs !== 1) begin n_err++; $display("FAIL t3_fs f=%0d got=%b/%0d exp=1/1", f, fs0, fs); end
    end
    go_idle();
    red_freq = '0; blue_freq = '0;
  endtask

  task automatic test_midframe_ts();
    int hr, hg, hb, fs, hr2, fs2; logic fs0;
    time_slots = 16'd256; sweep_time = 16'd0;
    red_phase = 9'h080; red_mag = 2'd0;
    green_phase = '0; blue_phase = '0; blue_mag = '0;
    pwm_en = 1'b1;
    tick();
    run_count(50, hr, hg, hb, fs, fs0);
    time_slots = 16'd128;
    run_count(206, hr2, hg, hb, fs2, fs0);
    n_vec++; if (hr + hr2 !== 128) begin n_err++; $display("FAIL t4_old_frame_high got=%0d exp=128", hr + hr2); end
    n_vec++; if (fs + fs2 !== 1) begin n_err++; $display("FAIL t4_old_frame_len got=%0d exp=1", fs + fs2); end
    for (int k = 0; k < 2; k++) begin
      run_count(128, hr, hg, hb, fs, fs0);
      n_vec++; if (hr !== 64) begin n_err++; $display("FAIL t4_new_frame_high k=%0d got=%0d exp=64", k, hr); end
      n_vec++; if (fs0 !== 1'b1 || fs !== 1) begin n_err++; $display("FAIL t4_new_frame_len k=%0d got=%b/%0d exp=1/1", k, fs0, fs); end
    end
    go_idle();
  endtask

  task automatic test_disable_at_boundary();
    int hr, hg, hb, fs; logic fs0;
    time_slots = 16'd16; sweep_time = 16'd1;
    red_freq = 13'h1000; red_phase = 9'h0F0; red_mag = 2'd0;
    pwm_en = 1'b1;
    tick();
    run_count(15, hr, hg, hb, fs, fs0);
    n_vec++; if (hr !== 15) begin n_err++; $display("FAIL t5_pre_high got=%0d exp=15", hr); end
    pwm_en = 1'b0;
    tick();
    n_vec++; if (active !== 1'b0 || pwm_r !== 1'b0) begin n_err++; $display("FAIL t5_disable got=%b%b exp=00", active, pwm_r); end
    tick();
    n_vec++; if (pwm_r !== 1'b0 || frame_start !== 1'b0) begin n_err++; $display("FAIL t5_after got=%b%b exp=00", pwm_r, frame_start); end
    red_phase = 9'h060; red_freq = '0;
    pwm_en = 1'b1;
    tick();
    n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL t5_reenable got=%b exp=1", active); end
    run_count(16, hr, hg, hb, fs, fs0);
    n_vec++; if (hr !== 6 || fs0 !== 1'b1) begin n_err++; $display("FAIL t5_reload got=%0d/%b exp=6/1", hr, fs0); end
    go_idle();
  endtask

  task automatic test_ts_zero();
    int hr, hg, hb, fs; logic fs0;
    time_slots = 16'd16; sweep_time = 16'd0; red_phase = 9'h080;
    pwm_en = 1'b1;
    tick();
    run_count(5, hr, hg, hb, fs, fs0);
    time_slots = 16'd0;
    run_count(10, hr, hg, hb, fs, fs0);
    n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL t7_midframe got=%b exp=1", active); end
    tick();
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL t7_stop got=%b exp=0", active); end
    tick();
    n_vec++; if (active !== 1'b0 || frame_start !== 1'b0) begin n_err++; $display("FAIL t7_no_restart got=%b%b exp=00", active, frame_start); end
    go_idle();
  endtask

  task automatic test_async_reset();
    int hr, hg, hb, fs; logic fs0;
    time_slots = 16'd64; sweep_time = 16'd0; red_phase = 9'h080; red_mag = 2'd0;
    pwm_en = 1'b1;
    tick();
    run_count(10, hr, hg, hb, fs, fs0);
    n_vec++; if (pwm_r !== 1'b1 || active !== 1'b1) begin n_err++; $display("FAIL t6_pre got=%b%b exp=11", pwm_r, active); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({pwm_r, frame_start, active} !== 3'b000) begin n_err++; $display("FAIL t6_async got=%b exp=000", {pwm_r, frame_start, active}); end
    tick();
    rst = 1'b0;
    tick();
    n_vec++; if (active !== 1'b1 || frame_start !== 1'b0) begin n_err++; $display("FAIL t6_reentry got=%b%b exp=10", active, frame_start); end
    tick();
    n_vec++; if (frame_start !== 1'b1 || pwm_r !== 1'b1) begin n_err++; $display("FAIL t6_first_frame got=%b%b exp=11", frame_start, pwm_r); end
    run_count(63, hr, hg, hb, fs, fs0);
    n_vec++; if (hr !== 31) begin n_err++; $display("FAIL t6_rest_frame got=%0d exp=31", hr); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_static_red();
    test_triangle_mag();
    test_sweep();
    test_midframe_ts();
    test_disable_at_boundary();
    test_ts_zero();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
